// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-through, no-write-allocate data cache placed
// between a single-cycle core's SRAM-style data port and a slow data memory.
//
// Ports:
//   clk, rst_n               clock (posedge) and asynchronous active-low reset
//   proc_cen                 0 = core accesses this cycle
//   proc_wen                 0 = write, 1 = read
//   proc_addr / proc_wdata   core word address and store data
//   proc_rdata               load data, non-zero only on an IDLE read hit
//   proc_stall               1 = core holds PC, register writes and proc_* inputs
//   mem_req / mem_we         single-word request to memory, 1 = write
//   mem_addr / mem_wdata     request address and write data, stable until ack
//   mem_ack / mem_rdata      one-cycle completion pulse with read data
//   hit_count / miss_count   saturating read hit / read miss counters
module dmem_cache #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              proc_cen,
    input  logic              proc_wen,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WORDS = LINES * LINE_WORDS;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StWrite,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;
    logic               refilled_q, refilled_d;
    logic               wr_hit_q, wr_hit_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    // Tag and data arrays need no reset: valid_q masks them.
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [WORDS];

    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [OFF_W-1:0]   addr_off;
    logic               hit;
    logic               last_word;
    logic               fill_we;
    logic               store_we;

    assign addr_tag  = proc_addr[ADDR_W-1 -: TAG_W];
    assign addr_idx  = proc_addr[OFF_W +: IDX_W];
    assign addr_off  = proc_addr[OFF_W-1:0];
    assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign last_word = (cnt_q == OFF_W'(LINE_WORDS - 1));

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        refilled_d = refilled_q;
        wr_hit_d   = wr_hit_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        proc_rdata = '0;
        proc_stall = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_we    = 1'b0;
        store_we   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!proc_cen) begin
                    if (proc_wen) begin
                        if (hit) begin
                            proc_rdata = data_q[{addr_idx, addr_off}];
                            // The re-lookup right after a refill was already counted as a miss.
                            if (!refilled_q) begin
                                hit_cnt_d = sat_inc(hit_cnt_q);
                            end
                            refilled_d = 1'b0;
                        end else begin
                            proc_stall       = 1'b1;
                            valid_d[addr_idx] = 1'b0;
                            cnt_d            = '0;
                            miss_cnt_d       = sat_inc(miss_cnt_q);
                            state_d          = StRefill;
                        end
                    end else begin
                        proc_stall = 1'b1;
                        wr_hit_d   = hit;
                        state_d    = StWrite;
                    end
                end
            end

            StRefill: begin
                proc_stall = 1'b1;
                mem_req    = 1'b1;
                mem_addr   = {addr_tag, addr_idx, cnt_q};
                if (mem_ack) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (last_word) begin
                        valid_d[addr_idx] = 1'b1;
                        refilled_d        = 1'b1;
                        state_d           = StIdle;
                    end
                end
            end

            StWrite: begin
                proc_stall = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = proc_addr;
                mem_wdata  = proc_wdata;
                if (mem_ack) begin
                    store_we = wr_hit_q;
                    state_d  = StDone;
                end
            end

            StDone: begin
                // Stall released so the core retires the store; no new lookup here.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            cnt_q      <= '0;
            refilled_q <= 1'b0;
            wr_hit_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            refilled_q <= refilled_d;
            wr_hit_q   <= wr_hit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[{addr_idx, cnt_q}] <= mem_rdata;
            if (last_word) begin
                tag_q[addr_idx] <= addr_tag;
            end
        end
        if (store_we) begin
            data_q[{addr_idx, addr_off}] <= proc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: self-checking bench for dmem_cache. A memory responder with a
// programmable ack latency serves requests; expected results come from a
// line-level cache model (valid/tag per index) and a reference memory image.
module tb_dmem_cache;

    localparam int unsigned CNT_W = 4;   // small so saturation is reachable
    localparam logic [31:0] CNT_MAX = 32'd15;

    logic             clk;
    logic             rst_n;
    logic             proc_cen;
    logic             proc_wen;
    logic [6:0]       proc_addr;
    logic [31:0]      proc_wdata;
    logic [31:0]      proc_rdata;
    logic             proc_stall;
    logic             mem_req;
    logic             mem_we;
    logic [6:0]       mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    dmem_cache #(
        .ADDR_W    (7),
        .LINE_WORDS(4),
        .LINES     (8),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .proc_cen  (proc_cen),
        .proc_wen  (proc_wen),
        .proc_addr (proc_addr),
        .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata),
        .proc_stall(proc_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder state and transaction log.
    logic [31:0] mem_arr [128];
    int          lat = 2;
    int          wcnt;
    int          n_acks = 0;
    int          stab_err = 0;
    logic [6:0]  cap_addr;
    logic        cap_we;
    logic [31:0] cap_wd;
    logic [6:0]  log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_wd   [$];

    // Reference model: memory image plus per-index valid/tag, counters.
    logic [31:0] ref_mem [128];
    bit          m_valid [8];
    logic [1:0]  m_tag   [8];
    logic [31:0] m_hits;
    logic [31:0] m_miss;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            mem_rdata = $urandom;
            if (!rst_n) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    wcnt    = 0;
                end
                if (mem_req) begin
                    wcnt++;
                    if (wcnt == 1) begin
                        cap_addr = mem_addr;
                        cap_we   = mem_we;
                        cap_wd   = mem_wdata;
                    end else if (mem_addr !== cap_addr || mem_we !== cap_we ||
                                 (cap_we && mem_wdata !== cap_wd)) begin
                        stab_err++;
                    end
                    if (wcnt >= lat) begin
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            mem_arr[mem_addr] = mem_wdata;
                        end else begin
                            mem_rdata = mem_arr[mem_addr];
                        end
                        log_addr.push_back(mem_addr);
                        log_we.push_back(mem_we);
                        log_wd.push_back(mem_wdata);
                        n_acks++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    // One core access, checked against the model. Returns rdata and stall cycles.
    task automatic do_access(input bit is_wr, input logic [6:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output int stalls);
        int         exp_stalls;
        int         exp_acks;
        int         nchk;
        bit         m_hit;
        bit         nz;
        int         stab0;
        logic [2:0] idx;
        logic [1:0] tg;
        logic [31:0] exp_rd;
        string      s;

        idx   = addr[4:2];
        tg    = addr[6:5];
        m_hit = m_valid[idx] && (m_tag[idx] == tg);
        if (is_wr) begin
            exp_stalls = 1 + lat;
            exp_acks   = 1;
        end else if (m_hit) begin
            exp_stalls = 0;
            exp_acks   = 0;
        end else begin
            exp_stalls = 1 + 4 * lat;
            exp_acks   = 4;
        end
        log_addr.delete();
        log_we.delete();
        log_wd.delete();
        stab0 = stab_err;

        @(negedge clk);
        proc_cen   = 1'b0;
        proc_wen   = !is_wr;
        proc_addr  = addr;
        proc_wdata = wd;
        #1;
        stalls = 0;
        nz     = 1'b0;
        while (proc_stall === 1'b1 && stalls < 200) begin
            stalls++;
            if (proc_rdata !== 32'h0) nz = 1'b1;
            @(negedge clk);
            #1;
        end
        rd = proc_rdata;
        @(posedge clk);
        #1;
        proc_cen = 1'b1;
        proc_wen = 1'b1;

        if (is_wr) begin
            ref_mem[addr] = wd;
            exp_rd        = 32'h0;
        end else begin
            exp_rd = ref_mem[addr];
            if (m_hit) begin
                if (m_hits < CNT_MAX) m_hits++;
            end else begin
                if (m_miss < CNT_MAX) m_miss++;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end

        s = $sformatf("%s@%02h", is_wr ? "wr" : "rd", addr);
        check_eq({s, " stall_cycles"}, stalls, exp_stalls);
        check_eq({s, " rdata"}, rd, exp_rd);
        check_eq({s, " rdata_zero_in_stall"}, {31'b0, nz}, 32'h0);
        check_eq({s, " mem_acks"}, log_addr.size(), exp_acks);
        check_eq({s, " req_stable"}, stab_err - stab0, 0);
        nchk = (log_addr.size() < exp_acks) ? log_addr.size() : exp_acks;
        for (int k = 0; k < nchk; k++) begin
            if (is_wr) begin
                check_eq({s, " mem_addr"}, {25'b0, log_addr[k]}, {25'b0, addr});
                check_eq({s, " mem_we"}, {31'b0, log_we[k]}, 32'h1);
                check_eq({s, " mem_wdata"}, log_wd[k], wd);
            end else begin
                check_eq($sformatf("%s refill_addr%0d", s, k), {25'b0, log_addr[k]},
                         {25'b0, addr[6:2], 2'(k)});
                check_eq($sformatf("%s refill_we%0d", s, k), {31'b0, log_we[k]}, 32'h0);
            end
        end
        check_eq({s, " hit_count"}, {28'b0, hit_count}, m_hits);
        check_eq({s, " miss_count"}, {28'b0, miss_count}, m_miss);
    endtask

    initial begin
        logic [31:0] rd;
        int          st;
        int          base;
        logic [CNT_W-1:0] m0;
        logic [6:0]  a;
        bit          w;

        for (int i = 0; i < 128; i++) begin
            mem_arr[i] = 32'hDEAD0000 | i;
            ref_mem[i] = 32'hDEAD0000 | i;
        end
        model_reset();
        rst_n      = 1'b0;
        proc_cen   = 1'b1;
        proc_wen   = 1'b1;
        proc_addr  = '0;
        proc_wdata = '0;
        #23;
        check_eq("reset mem_req", {31'b0, mem_req}, 32'h0);
        check_eq("reset mem_we", {31'b0, mem_we}, 32'h0);
        check_eq("reset proc_stall", {31'b0, proc_stall}, 32'h0);
        check_eq("reset proc_rdata", proc_rdata, 32'h0);
        check_eq("reset hit_count", {28'b0, hit_count}, 32'h0);
        check_eq("reset miss_count", {28'b0, miss_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read miss with latency 2.
        lat = 2;
        do_access(1'b0, 7'h05, 32'h0, rd, st);
        check_eq("t1 rdata", rd, 32'hDEAD0005);
        check_eq("t1 stall", st, 32'd9);
        check_eq("t1 miss", {28'b0, miss_count}, 32'd1);
        check_eq("t1 hit", {28'b0, hit_count}, 32'd0);

        // Same-line read hits.
        do_access(1'b0, 7'h06, 32'h0, rd, st);
        check_eq("t2 rdata", rd, 32'hDEAD0006);
        check_eq("t2 stall", st, 32'd0);
        check_eq("t2 hit", {28'b0, hit_count}, 32'd1);

        // Write hit, then read back.
        do_access(1'b1, 7'h06, 32'h12345678, rd, st);
        check_eq("t3 write stall", st, 32'd3);
        do_access(1'b0, 7'h06, 32'h0, rd, st);
        check_eq("t3 read", rd, 32'h12345678);
        check_eq("t3 read stall", st, 32'd0);

        // Write miss does not allocate.
        do_access(1'b1, 7'h40, 32'hA5A5A5A5, rd, st);
        check_eq("t4 mem written", mem_arr[7'h40], 32'hA5A5A5A5);
        do_access(1'b0, 7'h40, 32'h0, rd, st);
        check_eq("t4 read", rd, 32'hA5A5A5A5);
        check_eq("t4 miss", {28'b0, miss_count}, 32'd2);

        // Conflict on index 1.
        m0 = miss_count;
        do_access(1'b0, 7'h25, 32'h0, rd, st);
        do_access(1'b0, 7'h05, 32'h0, rd, st);
        do_access(1'b0, 7'h25, 32'h0, rd, st);
        check_eq("conflict misses", {28'b0, 4'(miss_count - m0)}, 32'd3);

        // Reset in the middle of a refill.
        base = n_acks;
        @(negedge clk);
        proc_cen  = 1'b0;
        proc_wen  = 1'b1;
        proc_addr = 7'h05;
        for (int i = 0; i < 100 && n_acks < base + 2; i++) @(negedge clk);
        check_eq("midrst acks_before", n_acks - base, 32'd2);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        proc_cen = 1'b1;
        #1;
        check_eq("midrst mem_req", {31'b0, mem_req}, 32'h0);
        check_eq("midrst mem_we", {31'b0, mem_we}, 32'h0);
        check_eq("midrst proc_stall", {31'b0, proc_stall}, 32'h0);
        check_eq("midrst proc_rdata", proc_rdata, 32'h0);
        check_eq("midrst miss_count", {28'b0, miss_count}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_access(1'b0, 7'h05, 32'h0, rd, st);
        check_eq("postrst rdata", rd, 32'hDEAD0005);

        // Randomized traffic with random latency; counters saturate at 15.
        for (int n = 0; n < 120; n++) begin
            lat = $urandom_range(1, 3);
            w   = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 1) == 1) a = 7'($urandom_range(0, 31));
            else a = 7'($urandom_range(0, 127));
            do_access(w, a, $urandom, rd, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout: got no end, required end of stimulus");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
